decoder3_8_seq: RTL
===================

Name: decoder3_8_seq

Overview:
- Sequential 3-to-8 one-hot decoder. It is the consumer-side counterpart of the 8-to-3 priority encoder.
- Accepts a 3-bit index over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles, followed by an optional idle gap.
- A one-entry holding buffer lets the next index be accepted while the current one is being driven.
- Sits between an encoded request/grant path and the one-hot select lines of downstream logic.

Parameters:
- HOLD, 4, cycles each one-hot output stays asserted; legal range 1..255.
- GAP, 1, forced all-zero cycles after each hold period; legal range 0..15.
- CNT_W, 8, width of the internal down-counter; must hold max(HOLD, GAP)-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_idx is valid this cycle
- in_ready  output  1  block can accept an index this cycle
- in_idx  input  3  encoded index 0..7
- y  output  8  one-hot decoded output; all zeros when not driving
- y_valid  output  1  y carries a live one-hot value
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse on the last DRIVE cycle of each index

Behaviour:
- Reset: one clock (clk); reset rst is asynchronous and active-high.
  - Asserting rst immediately forces y=8'h00, y_valid=0, busy=0, done=0, in_ready=1, state=IDLE, buffer empty, counter=0.
  - A reset mid-operation drops the current output and any buffered index; no done pulse is issued.
- Handshake:
  - A transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_ready = !buf_full. It is combinational from the buffer flag only, never from in_valid.
  - in_idx is sampled only on a transfer.
- All outputs are registered except in_ready and busy. busy is decoded from the state register.
- States: IDLE, DRIVE, GAP. A 2-bit encoding is acceptable.
- IDLE:
  - y=0, y_valid=0. The buffer is always empty here.
  - On a transfer, the next state is DRIVE, y=1<<in_idx, y_valid=1, cnt=HOLD-1.
  - Latency: transfer at edge N, y live from edge N through N+HOLD.
- DRIVE:
  - y and y_valid are held and cnt decrements each cycle.
  - A transfer during DRIVE writes the buffer.
  - Terminal cycle is when cnt==0. done=1 in that cycle only.
- Leaving DRIVE on the terminal cycle:
  - If GAP>0: next state GAP, y=0, y_valid=0, cnt=GAP-1.
  - If GAP==0 and a next index is available: stay in DRIVE, y=1<<next, cnt=HOLD-1, with no dead cycle.
  - If GAP==0 and no next index is available: next state IDLE, y=0.
- GAP:
  - y=0 and cnt decrements each cycle.
  - A transfer during GAP writes the buffer.
  - At cnt==0: if a next index is available, go to DRIVE with y=1<<next and cnt=HOLD-1; otherwise go to IDLE.
- Next-index availability, evaluated in terminal cycles (DRIVE with GAP==0, or end of GAP):
  - If buf_full, use the buffer contents and clear the buffer. in_ready was 0 in that cycle, so no write can collide.
  - Otherwise, if a transfer occurs in that same cycle, the input bypasses the buffer straight into y; the buffer stays empty.
- Width rules:
  - y always has exactly one bit set when y_valid=1, and is exactly 8'h00 when y_valid=0.
  - in_idx is fully decoded, so there is no illegal index.
- Throughput: with GAP=0, a continuous stream runs at one index per HOLD cycles. With HOLD=1 and GAP=0, that is one index per cycle with in_ready held at 1.
- Parameter checks: HOLD=0, GAP>15, or CNT_W too small must fail at elaboration. HOLD=1 is legal and means the first DRIVE cycle is also the terminal cycle.

Test Plan:
- Reset: HOLD=4, GAP=1, rst asserted asynchronously mid-DRIVE with y=8'h20 and the buffer full -> y=00, y_valid=0, busy=0, in_ready=1 before the next edge; after release, the buffered index is never emitted.
- Single index: HOLD=4, GAP=1, idx=5 transferred at edge 0 -> y=8'h20 for cycles 1-4, done=1 in cycle 4 only, y=00 in cycle 5 (GAP), busy=0 from cycle 6.
- Buffering/backpressure: HOLD=4, GAP=1, idx=3 at edge 0, idx=6 at edge 1, idx=1 held valid -> in_ready=0 from cycle 2. Required output: y=08 for cycles 1-4, 00 in cycle 5, 40 for cycles 6-9, then 02. Each index is emitted exactly once.
- Full-rate stream: HOLD=1, GAP=0, idx 0..7 on consecutive cycles with in_valid held high -> y=01,02,04,…,80 on consecutive cycles, in_ready constantly 1, done=1 every cycle, IDLE after the last index.
- Bypass at a terminal cycle: HOLD=2, GAP=2, idx=7 transferred exactly in the last GAP cycle after a prior idx=0 -> y=8'h80 on the very next cycle with no extra IDLE cycle, and buf_full never set.
- Sweep: random idx, in_valid and HOLD/GAP configurations -> scoreboard checks exact one-hot encoding, HOLD-cycle duration, GAP zero cycles, in-order delivery with no loss or duplication, and that done matches the number of transfers.

Source files
------------

// File: rtl/decoder3_8_seq.sv
// Sequential 3-to-8 one-hot decoder: accepts an index over valid/ready, drives its
// one-hot line for HOLD cycles, then GAP zero cycles, with a one-entry holding buffer.
module decoder3_8_seq #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_idx,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_LOAD = ((HOLD > GAP) ? HOLD : GAP) - 1;

  if (HOLD == 0 || HOLD > 255) begin : g_bad_hold
    $error("decoder3_8_seq: HOLD must be in 1..255");
  end
  if (GAP > 15) begin : g_bad_gap
    $error("decoder3_8_seq: GAP must be in 0..15");
  end
  if (CNT_W == 0 || 64'(MAX_LOAD) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("decoder3_8_seq: CNT_W too small for max(HOLD, GAP)-1");
  end

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       y_nx;
  logic             y_valid_nx;
  logic             done_nx;
  logic             buf_full, buf_full_nx;
  logic [2:0]       buf_idx, buf_idx_nx;
  logic             transfer;
  logic             have_next;
  logic [2:0]       next_idx;
  logic             launch;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'h01 << idx;
  endfunction

  assign in_ready  = ~buf_full;
  assign busy      = (state != S_IDLE);
  assign transfer  = in_valid & in_ready;
  // A buffered index always wins; it can only be full when in_ready is low.
  assign have_next = buf_full | transfer;
  assign next_idx  = buf_full ? buf_idx : in_idx;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    y_nx        = y;
    y_valid_nx  = y_valid;
    done_nx     = 1'b0;
    buf_full_nx = buf_full;
    buf_idx_nx  = buf_idx;
    launch      = 1'b0;

    case (state)
      S_IDLE: launch = transfer;
      S_DRIVE, S_GAP: begin
        if (transfer) begin
          buf_full_nx = 1'b1;
          buf_idx_nx  = in_idx;
        end
        if (cnt != '0) begin
          cnt_nx  = cnt - ONE;
          done_nx = (state == S_DRIVE) && (cnt == ONE);
        end else if (state == S_DRIVE && GAP > 0) begin
          state_nx   = S_GAP;
          y_nx       = '0;
          y_valid_nx = 1'b0;
          cnt_nx     = GAP_LOAD;
        end else if (have_next) begin
          // Terminal cycle: consume the buffer, or let a same-cycle transfer bypass it.
          launch      = 1'b1;
          buf_full_nx = 1'b0;
        end else begin
          state_nx   = S_IDLE;
          y_nx       = '0;
          y_valid_nx = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (launch) begin
      state_nx   = S_DRIVE;
      y_nx       = onehot(next_idx);
      y_valid_nx = 1'b1;
      cnt_nx     = HOLD_LOAD;
      done_nx    = (HOLD == 1);
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      done     <= 1'b0;
      buf_full <= 1'b0;
      // NOTE: buf_idx is gated by buf_full, but clearing it keeps reset state fully deterministic.
      buf_idx  <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      y        <= y_nx;
      y_valid  <= y_valid_nx;
      done     <= done_nx;
      buf_full <= buf_full_nx;
      buf_idx  <= buf_idx_nx;
    end
  end

endmodule
